// File: rtl/max_subtract.sv
// Softmax max-subtract stage: buffers one vector popped from the input FIFO, tracks its maximum,
// then streams saturated x[i] - max over a valid/ready handshake in FIFO pop order.
module max_subtract #(
  parameter int unsigned DW      = 32,
  parameter int unsigned VEC_LEN = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          fifo_empty_i,
  output logic          fifo_rd_en_o,
  input  logic [DW-1:0] fifo_data_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_last_o,
  output logic [DW-1:0] max_out_o,
  output logic          busy_o
);

  localparam int unsigned CntW = $clog2(VEC_LEN + 1);
  localparam int unsigned IdxW = $clog2(VEC_LEN);
  localparam logic [CntW-1:0] VecLenC = CntW'(VEC_LEN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(VEC_LEN - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [IdxW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  cap_q;
  logic signed [DW-1:0]  max_q, max_d;
  logic signed [DW-1:0]  buf_q [VEC_LEN];

  logic                  rd_en;
  logic                  cap_last;
  logic                  is_last;
  logic signed [DW:0]    diff;
  logic [DW-1:0]         sat_diff;

  assign rd_en    = (state_q == StLoad) && !fifo_empty_i && (rd_cnt_q < VecLenC);
  assign cap_last = cap_q && (wr_cnt_q == LastIdx);
  assign is_last  = (idx_q == LastIdx);

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    idx_d    = idx_q;
    max_d    = max_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty_i) state_d = StLoad;
      end
      StLoad: begin
        if (rd_en) rd_cnt_d = rd_cnt_q + 1'b1;
        if (cap_q) begin
          // First capture seeds the max; ties keep the earlier value.
          if ((wr_cnt_q == '0) || ($signed(fifo_data_i) > max_q)) max_d = fifo_data_i;
          if (cap_last) state_d = StEmit;
          else          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
      StEmit: begin
        if (out_ready_i) begin
          if (is_last) begin
            state_d  = StIdle;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            idx_d    = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      idx_q    <= '0;
      cap_q    <= 1'b0;
      max_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      idx_q    <= idx_d;
      cap_q    <= rd_en;
      max_q    <= max_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(VEC_LEN); i++) buf_q[i] <= '0;
    end else if ((state_q == StLoad) && cap_q) begin
      buf_q[wr_cnt_q] <= fifo_data_i;
    end
  end

  // Difference is never positive, so only negative overflow needs clamping.
  assign diff = {buf_q[idx_q][DW-1], buf_q[idx_q]} - {max_q[DW-1], max_q};
  always_comb begin
    sat_diff = diff[DW-1:0];
    if (diff[DW] && !diff[DW-1]) sat_diff = {1'b1, {(DW-1){1'b0}}};
  end

  assign fifo_rd_en_o = rd_en;
  assign out_valid_o  = (state_q == StEmit);
  assign out_data_o   = (state_q == StEmit) ? sat_diff : '0;
  assign out_last_o   = (state_q == StEmit) && is_last;
  assign max_out_o    = max_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: doc/max_subtract.md
Name: max_subtract

Overview:
- Consumer stage directly downstream of the input FIFO in the softmax datapath.
- Pops one vector of VEC_LEN signed fixed-point logits from the FIFO and buffers them.
- Computes the vector maximum, then streams x[i] − max for each element (numerically stabilised input to the exp stage), over a valid/ready handshake.

Parameters:
- DW, 32, element width: signed two's complement, same as FIFO data width.
- VEC_LEN, 8, elements per vector; must be ≥ 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read enable.
- fifo_data  input  DW  FIFO registered read data.
- out_data  output  DW  x[i] − max, saturated.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream ready.
- out_last  output  1  high with the final element of the vector.
- max_out  output  DW  maximum of the current vector; valid while busy is high in EMIT.
- busy  output  1  high in LOAD and EMIT.

Behaviour:
- Reset: rst low at any time, including mid-vector, immediately clears all state. Resulting values:
  - state = IDLE.
  - fifo_rd_en, out_valid, out_last, busy = 0.
  - out_data, max_out = 0.
  - All counters = 0.
  - Any partial vector is discarded; FIFO contents are not this block's concern.
- FIFO read timing: FIFO data is registered, so fifo_data is sampled one cycle after a cycle with fifo_rd_en=1 and fifo_empty=0.
- FIFO read rule: fifo_rd_en is never asserted while fifo_empty=1.
- States: IDLE, LOAD, EMIT.
- IDLE:
  - Go to LOAD when fifo_empty=0.
  - fifo_rd_en=0 in IDLE.
- LOAD:
  - fifo_rd_en = !fifo_empty && (rd_cnt < VEC_LEN).
  - rd_cnt increments on each effective read.
  - A 1-cycle-delayed copy of the effective-read strobe captures fifo_data into buf[wr_cnt]; wr_cnt then increments.
  - Running max:
    - First capture loads max unconditionally.
    - Later captures update it if fifo_data > max (signed compare).
    - Ties keep the existing value.
  - FIFO going empty mid-vector stalls LOAD with no state change until data returns.
  - When the capture with wr_cnt = VEC_LEN−1 completes, go to EMIT on the next cycle.
  - Throughput: back-to-back reads give 1 element/cycle.
- Latency: out_valid rises exactly 1 cycle after the final capture edge.
- EMIT:
  - out_valid=1.
  - out_data = sat(buf[idx] − max), computed as DW+1-bit signed.
  - Saturation: if the difference < −2^(DW−1), output −2^(DW−1). The result is always ≤ 0.
  - out_last = (idx == VEC_LEN−1).
  - On out_valid && out_ready, idx increments.
  - With out_ready=0, out_data, out_valid and out_last hold stable.
  - After the handshake with out_last=1: go to IDLE, clear counters, out_valid=0 next cycle.
  - fifo_rd_en=0 throughout EMIT; the next vector is not prefetched.
- IDLE→LOAD occurs at the earliest 1 cycle after the last handshake.
- The element equal to max always produces out_data = 0.
- Ordering: output order equals FIFO pop order.

Test Plan:
- Basic vector: VEC_LEN=4, push 5, −3, 12, 0, out_ready=1.
  - Expect out_data = −7, −15, 0, −12; out_last on the 4th; max_out = 12.
  - First out_valid arrives 1 cycle after the 4th capture.
- Backpressure: same vector, out_ready toggled 1,0,0,1,….
  - Each element is held stable while out_ready=0.
  - Exactly 4 handshakes; no duplicates or drops.
- Starved FIFO: elements arrive with 3-cycle gaps.
  - fifo_rd_en is never high while fifo_empty=1.
  - Results are identical to the basic vector case.
- Saturation (DW=8): vector −128, 127, 0, −1.
  - Expect out_data = −128 (saturated from −255), 0, −127, −128 (saturated from −128, exact).
- All-negative with ties: −9, −2, −2, −50.
  - Expect max_out = −2; out_data = −7, 0, 0, −48.
- Reset mid-LOAD: drive rst low after 2 captures, release, then push a fresh 4-vector 1, 2, 3, 4.
  - All outputs return to 0 immediately on reset.
  - Expect output −3, −2, −1, 0, with no stale data.
